// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the RV32 control pipeline: decoder bundle,
// per-stage retired subsets of it, and forwarding select encodings.
package ctrl_pipe_pkg;

  localparam int REG_AW_DEF = 5;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  // Bundle once Branch has been consumed in ID.
  typedef struct packed {
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  localparam ctrl_t    BUBBLE    = '0;
  localparam ex_ctrl_t EX_BUBBLE = '0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Signal bundle between the ID decoder / EX-MEM-WB datapath and ctrl_pipe.
interface ctrl_pipe_if
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
);
  logic              Branch_i;
  logic              MemRead_i;
  logic              MemtoReg_i;
  logic              MemWrite_i;
  logic              ALUSrc_i;
  logic              RegWrite_i;
  logic [1:0]        ALUOp_i;
  logic [REG_AW-1:0] rs1_i;
  logic [REG_AW-1:0] rs2_i;
  logic [REG_AW-1:0] rd_i;
  logic              br_eq_i;

  logic [1:0]        ALUOp_ex_o;
  logic              ALUSrc_ex_o;
  logic              MemRead_mem_o;
  logic              MemWrite_mem_o;
  logic              RegWrite_wb_o;
  logic              MemtoReg_wb_o;
  logic [REG_AW-1:0] rd_wb_o;
  logic [1:0]        ForwardA_o;
  logic [1:0]        ForwardB_o;
  logic              stall_o;
  logic              flush_o;

  modport master (
    output Branch_i, MemRead_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i,
           ALUOp_i, rs1_i, rs2_i, rd_i, br_eq_i,
    input  ALUOp_ex_o, ALUSrc_ex_o, MemRead_mem_o, MemWrite_mem_o,
           RegWrite_wb_o, MemtoReg_wb_o, rd_wb_o, ForwardA_o, ForwardB_o,
           stall_o, flush_o
  );

  modport slave (
    input  Branch_i, MemRead_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i,
           ALUOp_i, rs1_i, rs2_i, rd_i, br_eq_i,
    output ALUOp_ex_o, ALUSrc_ex_o, MemRead_mem_o, MemWrite_mem_o,
           RegWrite_wb_o, MemtoReg_wb_o, rd_wb_o, ForwardA_o, ForwardB_o,
           stall_o, flush_o
  );

endinterface

// File: rtl/ctrl_pipe_fwd_unit.sv
// EX-stage operand forwarding selects; EX/MEM result beats MEM/WB result.
module ctrl_pipe_fwd_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_reg_write,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_reg_write,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

  logic [1:0][REG_AW-1:0] src;
  logic [1:0][1:0]        sel;

  assign src = {rs2, rs1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic mem_hit;
      logic wb_hit;
      assign mem_hit = ex_mem_reg_write && (ex_mem_rd != ZERO_ADDR) && (ex_mem_rd == src[gi]);
      assign wb_hit  = mem_wb_reg_write && (mem_wb_rd != ZERO_ADDR) && (mem_wb_rd == src[gi]);
      assign sel[gi] = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);
    end
  endgenerate

  assign forward_a = sel[0];
  assign forward_b = sel[1];

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall, branch flush
// and EX forwarding for a 5-stage RV32 pipeline.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ctrl_pipe_if.slave  bus
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

  ex_ctrl_t          id_ex_ctrl_reg,  id_ex_ctrl_next;
  logic [REG_AW-1:0] id_ex_rd_reg,    id_ex_rd_next;
  logic [REG_AW-1:0] id_ex_rs1_reg,   id_ex_rs1_next;
  logic [REG_AW-1:0] id_ex_rs2_reg,   id_ex_rs2_next;
  mem_ctrl_t         ex_mem_ctrl_reg;
  logic [REG_AW-1:0] ex_mem_rd_reg;
  wb_ctrl_t          mem_wb_ctrl_reg;
  logic [REG_AW-1:0] mem_wb_rd_reg;

  logic stall;
  logic flush;

  always_comb begin
    stall = id_ex_ctrl_reg.mem_read && (id_ex_rd_reg != ZERO_ADDR) &&
            ((id_ex_rd_reg == bus.rs1_i) || (id_ex_rd_reg == bus.rs2_i));
    flush = bus.Branch_i && bus.br_eq_i && !stall;

    // A branch never writes a register or memory, whatever the decoder says.
    id_ex_ctrl_next = '{
      mem_read:   bus.MemRead_i,
      mem_to_reg: bus.MemtoReg_i,
      alu_op:     bus.ALUOp_i,
      mem_write:  bus.MemWrite_i && !bus.Branch_i,
      alu_src:    bus.ALUSrc_i,
      reg_write:  bus.RegWrite_i && !bus.Branch_i
    };
    id_ex_rd_next  = bus.rd_i;
    id_ex_rs1_next = bus.rs1_i;
    id_ex_rs2_next = bus.rs2_i;

    if (stall) begin
      id_ex_ctrl_next = EX_BUBBLE;
      id_ex_rd_next   = '0;
      id_ex_rs1_next  = '0;
      id_ex_rs2_next  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_ex_ctrl_reg  <= EX_BUBBLE;
      id_ex_rd_reg    <= '0;
      id_ex_rs1_reg   <= '0;
      id_ex_rs2_reg   <= '0;
      ex_mem_ctrl_reg <= '0;
      ex_mem_rd_reg   <= '0;
      mem_wb_ctrl_reg <= '0;
      mem_wb_rd_reg   <= '0;
    end else begin
      id_ex_ctrl_reg  <= id_ex_ctrl_next;
      id_ex_rd_reg    <= id_ex_rd_next;
      id_ex_rs1_reg   <= id_ex_rs1_next;
      id_ex_rs2_reg   <= id_ex_rs2_next;
      ex_mem_ctrl_reg <= '{
        mem_read:   id_ex_ctrl_reg.mem_read,
        mem_write:  id_ex_ctrl_reg.mem_write,
        mem_to_reg: id_ex_ctrl_reg.mem_to_reg,
        reg_write:  id_ex_ctrl_reg.reg_write
      };
      ex_mem_rd_reg   <= id_ex_rd_reg;
      mem_wb_ctrl_reg <= '{
        mem_to_reg: ex_mem_ctrl_reg.mem_to_reg,
        reg_write:  ex_mem_ctrl_reg.reg_write
      };
      mem_wb_rd_reg   <= ex_mem_rd_reg;
    end
  end

  ctrl_pipe_fwd_unit #(
    .REG_AW   (REG_AW),
    .ZERO_REG (ZERO_REG)
  ) u_fwd (
    .rs1              (id_ex_rs1_reg),
    .rs2              (id_ex_rs2_reg),
    .ex_mem_rd        (ex_mem_rd_reg),
    .ex_mem_reg_write (ex_mem_ctrl_reg.reg_write),
    .mem_wb_rd        (mem_wb_rd_reg),
    .mem_wb_reg_write (mem_wb_ctrl_reg.reg_write),
    .forward_a        (bus.ForwardA_o),
    .forward_b        (bus.ForwardB_o)
  );

  assign bus.ALUOp_ex_o     = id_ex_ctrl_reg.alu_op;
  assign bus.ALUSrc_ex_o    = id_ex_ctrl_reg.alu_src;
  assign bus.MemRead_mem_o  = ex_mem_ctrl_reg.mem_read;
  assign bus.MemWrite_mem_o = ex_mem_ctrl_reg.mem_write;
  assign bus.RegWrite_wb_o  = mem_wb_ctrl_reg.reg_write;
  assign bus.MemtoReg_wb_o  = mem_wb_ctrl_reg.mem_to_reg;
  assign bus.rd_wb_o        = mem_wb_rd_reg;
  assign bus.stall_o        = stall;
  assign bus.flush_o        = flush;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed vectors for ctrl_pipe: an instruction stream table plus hand-written
// load-use, branch-after-load and mid-flight reset sequences.
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       br_eq;
  } instr_t;

  typedef struct packed {
    instr_t     in;
    logic       stall;
    logic       flush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mrd;
    logic       mwr;
    logic       rw;
    logic       m2r;
    logic [4:0] rd;
  } vec_t;

  localparam int NVEC = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  vec_t vecs [NVEC];

  ctrl_pipe_if #(.REG_AW(5)) bus ();

  ctrl_pipe #(.REG_AW(5), .ZERO_REG(0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t nop();
    instr_t i;
    i = '0;
    return i;
  endfunction

  function automatic instr_t r_type(input int rd, input int rs1, input int rs2);
    instr_t i;
    i = '0;
    i.alu_op = 2'b10; i.reg_write = 1'b1;
    i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    return i;
  endfunction

  function automatic instr_t i_alu(input int rd, input int rs1);
    instr_t i;
    i = r_type(rd, rs1, 0);
    i.alu_src = 1'b1;
    return i;
  endfunction

  function automatic instr_t lw(input int rd, input int rs1);
    instr_t i;
    i = '0;
    i.mem_read = 1'b1; i.mem_to_reg = 1'b1; i.alu_src = 1'b1; i.reg_write = 1'b1;
    i.rd = 5'(rd); i.rs1 = 5'(rs1);
    return i;
  endfunction

  function automatic instr_t sw(input int rs1, input int rs2);
    instr_t i;
    i = '0;
    i.mem_write = 1'b1; i.alu_src = 1'b1;
    i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    return i;
  endfunction

  function automatic instr_t beq(input int rs1, input int rs2, input logic eq);
    instr_t i;
    i = '0;
    i.branch = 1'b1; i.alu_op = 2'b01; i.br_eq = eq;
    i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    return i;
  endfunction

  function automatic vec_t ev(input instr_t in, input logic st, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic [1:0] aop, input logic asrc,
                              input logic mrd, input logic mwr, input logic rw,
                              input logic m2r, input int rd);
    vec_t v;
    v.in = in; v.stall = st; v.flush = fl; v.fa = fa; v.fb = fb;
    v.alu_op = aop; v.alu_src = asrc; v.mrd = mrd; v.mwr = mwr;
    v.rw = rw; v.m2r = m2r; v.rd = 5'(rd);
    return v;
  endfunction

  task automatic drive(input instr_t in);
    bus.Branch_i   = in.branch;
    bus.MemRead_i  = in.mem_read;
    bus.MemtoReg_i = in.mem_to_reg;
    bus.ALUOp_i    = in.alu_op;
    bus.MemWrite_i = in.mem_write;
    bus.ALUSrc_i   = in.alu_src;
    bus.RegWrite_i = in.reg_write;
    bus.rs1_i      = in.rs1;
    bus.rs2_i      = in.rs2;
    bus.rd_i       = in.rd;
    bus.br_eq_i    = in.br_eq;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    rst = 1'b1;
    drive(nop());
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;

    //            instr             st fl fa fb aop src mrd mwr rw m2r rd
    vecs[0]  = ev(r_type(3, 1, 2),  0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0);
    vecs[1]  = ev(r_type(4, 5, 6),  0, 0, 0, 0, 2, 0,  0,  0,  0, 0,  0);
    vecs[2]  = ev(r_type(7, 4, 4),  0, 0, 0, 0, 2, 0,  0,  0,  0, 0,  0);
    vecs[3]  = ev(i_alu(0, 0),      0, 0, 2, 2, 2, 0,  0,  0,  1, 0,  3);
    vecs[4]  = ev(r_type(1, 0, 0),  0, 0, 0, 0, 2, 1,  0,  0,  1, 0,  4);
    vecs[5]  = ev(r_type(9, 1, 2),  0, 0, 0, 0, 2, 0,  0,  0,  1, 0,  7);
    vecs[6]  = ev(r_type(9, 3, 1),  0, 0, 2, 0, 2, 0,  0,  0,  1, 0,  0);
    vecs[7]  = ev(r_type(10, 9, 2), 0, 0, 0, 1, 2, 0,  0,  0,  1, 0,  1);
    vecs[8]  = ev(lw(0, 1),         0, 0, 2, 0, 2, 0,  0,  0,  1, 0,  9);
    vecs[9]  = ev(r_type(11, 0, 0), 0, 0, 0, 0, 0, 1,  0,  0,  1, 0,  9);
    vecs[10] = ev(nop(),            0, 0, 0, 0, 2, 0,  1,  0,  1, 0, 10);
    vecs[11] = ev(beq(1, 2, 1'b1),  0, 1, 0, 0, 0, 0,  0,  0,  1, 1,  0);
    vecs[12] = ev(beq(1, 2, 1'b0),  0, 0, 0, 0, 1, 0,  0,  0,  1, 0, 11);
    vecs[13] = ev(sw(1, 5),         0, 0, 0, 0, 1, 0,  0,  0,  0, 0,  0);
    vecs[14] = ev(nop(),            0, 0, 0, 0, 0, 1,  0,  0,  0, 0,  0);
    vecs[15] = ev(nop(),            0, 0, 0, 0, 0, 0,  0,  1,  0, 0,  0);

    do_reset();

    // Instruction stream: one vector per cycle, no stalls expected.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].in);
      @(negedge clk);
      chk($sformatf("v%0d stall", i),    int'(bus.stall_o),        int'(vecs[i].stall));
      chk($sformatf("v%0d flush", i),    int'(bus.flush_o),        int'(vecs[i].flush));
      chk($sformatf("v%0d fwd_a", i),    int'(bus.ForwardA_o),     int'(vecs[i].fa));
      chk($sformatf("v%0d fwd_b", i),    int'(bus.ForwardB_o),     int'(vecs[i].fb));
      chk($sformatf("v%0d aluop_ex", i), int'(bus.ALUOp_ex_o),     int'(vecs[i].alu_op));
      chk($sformatf("v%0d alusrc_ex", i),int'(bus.ALUSrc_ex_o),    int'(vecs[i].alu_src));
      chk($sformatf("v%0d memrd_mem", i),int'(bus.MemRead_mem_o),  int'(vecs[i].mrd));
      chk($sformatf("v%0d memwr_mem", i),int'(bus.MemWrite_mem_o), int'(vecs[i].mwr));
      chk($sformatf("v%0d regwr_wb", i), int'(bus.RegWrite_wb_o),  int'(vecs[i].rw));
      chk($sformatf("v%0d m2r_wb", i),   int'(bus.MemtoReg_wb_o),  int'(vecs[i].m2r));
      chk($sformatf("v%0d rd_wb", i),    int'(bus.rd_wb_o),        int'(vecs[i].rd));
      $display("vec %2d: stall=%0b flush=%0b fa=%b fb=%b rw_wb=%0b rd_wb=%0d",
               i, bus.stall_o, bus.flush_o, bus.ForwardA_o, bus.ForwardB_o,
               bus.RegWrite_wb_o, bus.rd_wb_o);
      next_cycle();
    end

    // Load-use: lw x5,0(x1); add x6,x5,x2 (held in ID during the stall).
    do_reset();
    drive(lw(5, 1));
    @(negedge clk);
    chk("lu lw stall", int'(bus.stall_o), 0);
    next_cycle();
    drive(r_type(6, 5, 2));
    @(negedge clk);
    chk("lu stall", int'(bus.stall_o), 1);
    chk("lu flush", int'(bus.flush_o), 0);
    next_cycle();
    @(negedge clk);
    chk("lu stall released", int'(bus.stall_o), 0);
    chk("lu bubble aluop",   int'(bus.ALUOp_ex_o), 0);
    next_cycle();
    drive(nop());
    @(negedge clk);
    chk("lu fwd_a",       int'(bus.ForwardA_o), 1);
    chk("lu fwd_b",       int'(bus.ForwardB_o), 0);
    chk("lu bubble mem",  int'(bus.MemRead_mem_o), 0);
    chk("lu lw regwr_wb", int'(bus.RegWrite_wb_o), 1);
    chk("lu lw rd_wb",    int'(bus.rd_wb_o), 5);
    $display("seq load-use: add in EX, fa=%b fb=%b", bus.ForwardA_o, bus.ForwardB_o);
    next_cycle();
    @(negedge clk);
    chk("lu bubble regwr_wb", int'(bus.RegWrite_wb_o), 0);
    next_cycle();
    @(negedge clk);
    chk("lu add regwr_wb", int'(bus.RegWrite_wb_o), 1);
    chk("lu add rd_wb",    int'(bus.rd_wb_o), 6);

    // Store of a just-loaded register stalls on the rs2 compare.
    do_reset();
    drive(lw(5, 1));
    next_cycle();
    drive(sw(2, 5));
    @(negedge clk);
    chk("st-after-ld stall", int'(bus.stall_o), 1);
    $display("seq store-after-load: stall=%0b", bus.stall_o);

    // Branch on a loaded operand: stall first, flush once operands are ready.
    do_reset();
    drive(lw(1, 2));
    next_cycle();
    drive(beq(1, 3, 1'b1));
    @(negedge clk);
    chk("br-ld stall", int'(bus.stall_o), 1);
    chk("br-ld flush", int'(bus.flush_o), 0);
    next_cycle();
    @(negedge clk);
    chk("br-ld stall2", int'(bus.stall_o), 0);
    chk("br-ld flush2", int'(bus.flush_o), 1);
    $display("seq branch-after-load: stall=%0b flush=%0b", bus.stall_o, bus.flush_o);
    next_cycle();
    drive(nop());
    @(negedge clk);
    chk("br-ld flush off", int'(bus.flush_o), 0);

    // Reset mid-flight with three instructions in the stages.
    do_reset();
    drive(r_type(3, 1, 2));
    next_cycle();
    drive(r_type(4, 1, 2));
    next_cycle();
    drive(r_type(5, 4, 3));
    next_cycle();
    drive(nop());
    @(negedge clk);
    chk("rst pre regwr_wb", int'(bus.RegWrite_wb_o), 1);
    chk("rst pre rd_wb",    int'(bus.rd_wb_o), 3);
    chk("rst pre fwd_a",    int'(bus.ForwardA_o), 2);
    #2 rst = 1'b1;
    #1;
    chk("rst async regwr_wb", int'(bus.RegWrite_wb_o), 0);
    chk("rst async rd_wb",    int'(bus.rd_wb_o), 0);
    chk("rst async aluop_ex", int'(bus.ALUOp_ex_o), 0);
    chk("rst async fwd_a",    int'(bus.ForwardA_o), 0);
    chk("rst async fwd_b",    int'(bus.ForwardB_o), 0);
    $display("seq reset mid-flight: rw_wb=%0b rd_wb=%0d", bus.RegWrite_wb_o, bus.rd_wb_o);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst post c%0d regwr_wb", c), int'(bus.RegWrite_wb_o), 0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
